// File: rtl/stream_update_pkg.sv
// Shared types and helpers for the bit-stream weight update decoder.
package stream_update_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_APPLY,
    ST_DONE
  } su_fsm_t;

  // Default signed conductance step applied per x/delta coincidence.
  localparam int DG_EQUIVALENT_DEF = 25;

  // Working width of the saturating adder; wide enough for any realistic WW.
  localparam int SAT_W = 64;

  // Signed add of a and d, clamped to the signed range of a width-bit value.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] d,
    input int                      width
  );
    logic signed [SAT_W-1:0] s, hi, lo;
    s  = a + d;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi)      sat_add = hi;
    else if (s < lo) sat_add = lo;
    else             sat_add = s;
  endfunction

endpackage

// File: rtl/stream_coincidence_counter.sv
// m x n AND array with one coincidence counter per crossbar cell.
module stream_coincidence_counter
  import stream_update_pkg::*;
#(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              valid,
  input  logic [M-1:0]      x,
  input  logic [N-1:0]      delta,
  output logic [M*N*CW-1:0] counts
);

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [CW-1:0] r_cnt;

      // Count rows where both the x and delta pulses are present.
      always_ff @(posedge clk) begin
        if (rst || clr)
          r_cnt <= '0;
        else if (valid && x[gi] && delta[gj])
          r_cnt <= r_cnt + CW'(1);
      end

      assign counts[(gi*N+gj)*CW +: CW] = r_cnt;
    end
  end

endmodule

// File: rtl/stream_update_decoder.sv
// Reads per-row bit-streams, counts coincidences and applies one saturating
// weight update per transaction to an internal m x n signed weight array.
module stream_update_decoder
  import stream_update_pkg::*;
#(
  parameter int m             = 2,
  parameter int n             = 2,
  parameter int bl            = 10,
  parameter int dG_equivalent = DG_EQUIVALENT_DEF,
  parameter int WW            = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(bl+1)-1:0]   num_rows,
  input  logic                      dir,
  input  logic                      w_load,
  input  logic [m*n*WW-1:0]         w_init,
  output logic                      rd_en,
  output logic [$clog2(bl)-1:0]     rd_addr,
  input  logic [m-1:0]              rd_x,
  input  logic [n-1:0]              rd_delta,
  output logic [m*n*WW-1:0]         weights,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = $clog2(bl + 1);
  localparam int AW = $clog2(bl);
  localparam int EW = WW + CW + 8;
  localparam logic signed [EW-1:0] DG = EW'(dG_equivalent);

  su_fsm_t             r_state, w_next_state;
  logic [CW-1:0]       r_num_rows;
  logic                r_dir;
  logic [AW-1:0]       r_addr;
  logic                r_rd_valid;
  logic [m*n*WW-1:0]   r_weights;

  logic [CW-1:0]       w_num_clamped;
  logic                w_last;
  logic                w_start_acc;
  logic                w_load_acc;
  logic                w_apply;
  logic [m*n*CW-1:0]   w_counts;
  logic [m*n*WW-1:0]   w_weights_next;

  assign w_num_clamped = (num_rows > CW'(bl)) ? CW'(bl) : num_rows;
  assign w_last        = (CW'(r_addr) + CW'(1)) == r_num_rows;

  assign rd_en   = (r_state == ST_STREAM);
  assign rd_addr = r_addr;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign weights = r_weights;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a weight load in IDLE takes priority over start.
  always_comb begin
    w_next_state = r_state;
    w_start_acc  = 1'b0;
    w_load_acc   = 1'b0;
    w_apply      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_load_acc = 1'b1;
        end else if (start) begin
          w_start_acc  = 1'b1;
          w_next_state = (w_num_clamped == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: if (w_last) w_next_state = ST_DRAIN;
      ST_DRAIN:  w_next_state = ST_APPLY;
      ST_APPLY: begin
        w_apply      = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Transaction parameters are captured once at start and held throughout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_rows <= '0;
      r_dir      <= 1'b0;
    end else if (w_start_acc) begin
      r_num_rows <= w_num_clamped;
      r_dir      <= dir;
    end
  end

  // Row address: cleared on start, stepped each STREAM cycle, parked on the last row.
  always_ff @(posedge clk) begin
    if (rst)
      r_addr <= '0;
    else if (w_start_acc)
      r_addr <= '0;
    else if (r_state == ST_STREAM && !w_last)
      r_addr <= r_addr + AW'(1);
  end

  // Memory data arrives one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (rst) r_rd_valid <= 1'b0;
    else     r_rd_valid <= rd_en;
  end

  stream_coincidence_counter #(
    .M  (m),
    .N  (n),
    .CW (CW)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_start_acc | w_apply),
    .valid  (r_rd_valid),
    .x      (rd_x),
    .delta  (rd_delta),
    .counts (w_counts)
  );

  // Per-cell step dG*c, signed by direction, saturated into the weight range.
  for (genvar gi = 0; gi < m; gi++) begin : g_row
    for (genvar gj = 0; gj < n; gj++) begin : g_col
      localparam int K = gi*n + gj;
      logic signed [WW-1:0] w_cur;
      logic signed [EW-1:0] w_cnt_e;
      logic signed [EW-1:0] w_step;
      logic signed [SAT_W-1:0] w_delta;

      assign w_cur   = r_weights[K*WW +: WW];
      assign w_cnt_e = EW'(w_counts[K*CW +: CW]);
      assign w_step  = DG * w_cnt_e;
      assign w_delta = r_dir ? SAT_W'(w_step) : -SAT_W'(w_step);
      assign w_weights_next[K*WW +: WW] = WW'(sat_add(SAT_W'(w_cur), w_delta, WW));
    end
  end

  // Weight array: loaded from w_init in IDLE, updated once in APPLY.
  always_ff @(posedge clk) begin
    if (rst)
      r_weights <= '0;
    else if (w_load_acc)
      r_weights <= w_init;
    else if (w_apply)
      r_weights <= w_weights_next;
  end

endmodule

// File: tb/tb_stream_update_decoder.sv
// Directed bench for stream_update_decoder with a 1-cycle-latency row memory.
module tb_stream_update_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  num_rows;
  logic        dir;
  logic        w_load;
  logic [63:0] w_init;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [1:0]  rd_x;
  logic [1:0]  rd_delta;
  logic [63:0] weights;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [1:0] mem_x [16];
  logic [1:0] mem_d [16];

  // Results captured by run().
  int          done_cyc;
  int          en_cnt;
  int          max_addr;
  logic [11:0] addr_seq;
  logic [63:0] wsnap;

  stream_update_decoder #(
    .m(2), .n(2), .bl(10), .dG_equivalent(25), .WW(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_rows (num_rows),
    .dir      (dir),
    .w_load   (w_load),
    .w_init   (w_init),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_x     (rd_x),
    .rd_delta (rd_delta),
    .weights  (weights),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Row memory: returns data the cycle after rd_en; all-ones otherwise so that
  // counting without a valid read is visible.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x     <= mem_x[rd_addr];
      rd_delta <= mem_d[rd_addr];
    end else begin
      rd_x     <= 2'b11;
      rd_delta <= 2'b11;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a00, input int a01, input int a10, input int a11);
    return {16'(a11), 16'(a10), 16'(a01), 16'(a00)};
  endfunction

  // Rows below cnt get the given pattern; the rest are poisoned with all-ones.
  task automatic set_rows(input logic [1:0] x, input logic [1:0] d, input int cnt);
    for (int r = 0; r < 16; r++) begin
      mem_x[r] = (r < cnt) ? x : 2'b11;
      mem_d[r] = (r < cnt) ? d : 2'b11;
    end
  endtask

  task automatic load_w(input logic [63:0] val);
    @(negedge clk);
    w_init = val;
    w_load = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
  endtask

  // One transaction; poke>0 pulses start and w_load (with junk w_init) in that cycle.
  task automatic run(input logic [3:0] nr, input logic d, input int poke);
    done_cyc = -1; en_cnt = 0; max_addr = 0; addr_seq = '0; wsnap = '0;
    @(negedge clk);
    num_rows = nr;
    dir      = d;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      if (rd_en) begin
        en_cnt++;
        addr_seq = {addr_seq[7:0], rd_addr};
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      end
      if (done) begin
        done_cyc = k;
        wsnap    = weights;
      end
      start  = (k == poke);
      w_load = (k == poke);
      if (k == poke) w_init = 64'hDEAD_BEEF_1234_5678;
      if (done_cyc < 0) @(negedge clk);
    end
    start  = 1'b0;
    w_load = 1'b0;
    @(negedge clk);
    chk("done_pulse_end", {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_rows = '0; dir = 1'b0;
    w_load = 1'b0; w_init = '0; rd_x = '0; rd_delta = '0;
    set_rows(2'b00, 2'b00, 0);
    repeat (3) @(negedge clk);
    chk("rst_weights", weights, 64'd0);
    chk("rst_ctrl", {60'd0, rd_en, busy, done, 1'b0}, 64'd0);
    chk("rst_addr", rd_addr, 64'd0);
    rst = 1'b0;

    // Basic depress: c00=c10=3.
    set_rows(2'b11, 2'b01, 3);
    run(4'd3, 1'b0, 0);
    chk("dep_done_cyc", done_cyc, 64'd6);
    chk("dep_addr_seq", addr_seq, 64'h012);
    chk("dep_weights", wsnap, pk(-75, 0, -75, 0));

    // Potentiate, full length from 100.
    load_w(pk(100, 100, 100, 100));
    chk("load_weights", weights, pk(100, 100, 100, 100));
    chk("load_busy", busy, 64'd0);
    set_rows(2'b01, 2'b11, 10);
    run(4'd10, 1'b1, 0);
    chk("pot_done_cyc", done_cyc, 64'd13);
    chk("pot_en_cnt", en_cnt, 64'd10);
    chk("pot_weights", wsnap, pk(350, 350, 100, 100));

    // Negative saturation.
    load_w(pk(-32760, 0, 0, 0));
    set_rows(2'b01, 2'b01, 1);
    run(4'd1, 1'b0, 0);
    chk("satn_done_cyc", done_cyc, 64'd4);
    chk("satn_weights", wsnap, pk(-32768, 0, 0, 0));

    // Positive saturation.
    load_w(pk(32760, 0, 0, 0));
    run(4'd1, 1'b1, 0);
    chk("satp_weights", wsnap, pk(32767, 0, 0, 0));

    // Zero rows: no reads, immediate done, weights untouched.
    run(4'd0, 1'b1, 0);
    chk("zero_done_cyc", done_cyc, 64'd1);
    chk("zero_en_cnt", en_cnt, 64'd0);
    chk("zero_weights", wsnap, pk(32767, 0, 0, 0));

    // Clamp 15 -> 10; rows 10+ are poisoned.
    set_rows(2'b10, 2'b10, 10);
    run(4'd15, 1'b1, 0);
    chk("clamp_done_cyc", done_cyc, 64'd13);
    chk("clamp_en_cnt", en_cnt, 64'd10);
    chk("clamp_max_addr", max_addr, 64'd9);
    chk("clamp_weights", wsnap, pk(32767, 0, 0, 250));

    // start/w_load pulsed mid-STREAM are ignored.
    run(4'd3, 1'b0, 2);
    chk("ign_done_cyc", done_cyc, 64'd6);
    chk("ign_weights", wsnap, pk(32767, 0, 0, 175));

    // w_load with start in IDLE: load only.
    @(negedge clk);
    w_init = pk(1, 2, 3, 4);
    w_load = 1'b1;
    start  = 1'b1;
    num_rows = 4'd3;
    @(negedge clk);
    w_load = 1'b0;
    start  = 1'b0;
    chk("ldst_busy", busy, 64'd0);
    chk("ldst_weights", weights, pk(1, 2, 3, 4));
    repeat (3) @(negedge clk);
    chk("ldst_idle", {62'd0, busy, rd_en}, 64'd0);

    // Reset mid-STREAM, then a fresh transaction.
    load_w(64'd0);
    set_rows(2'b11, 2'b11, 10);
    @(negedge clk);
    num_rows = 4'd5;
    dir      = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_weights", weights, 64'd0);
    chk("mrst_ctrl", {61'd0, rd_en, busy, done}, 64'd0);
    chk("mrst_addr", rd_addr, 64'd0);
    rst = 1'b0;
    set_rows(2'b11, 2'b11, 2);
    run(4'd2, 1'b1, 0);
    chk("fresh_done_cyc", done_cyc, 64'd5);
    chk("fresh_weights", wsnap, pk(50, 50, 50, 50));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
